// File: rtl/chunked_adder_if.sv
// Operand/result handshake bundle for chunked_adder.
// The ovf signal exists only when CHUNKED_ADDER_OVERFLOW_EN is defined.
interface chunked_adder_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
    logic             ovf;
`endif

    // Producer/consumer side
    modport master (
`ifdef CHUNKED_ADDER_OVERFLOW_EN
        input  ovf,
`endif
        output in_valid, x, y, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    // Adder side
    modport slave (
`ifdef CHUNKED_ADDER_OVERFLOW_EN
        output ovf,
`endif
        input  in_valid, x, y, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/chunked_adder.sv
// Multi-cycle add/subtract: WIDTH-bit operands summed CHUNK bits per clock via a carry register.
// Optional signed-overflow output enabled by macro CHUNKED_ADDER_OVERFLOW_EN.
module chunked_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic            clk,
    input  logic            rst,
    chunked_adder_if.slave  bus
);
    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e           state_q,     state_d;
    logic [WIDTH-1:0] a_q,         a_d;
    logic [WIDTH-1:0] b_q,         b_d;
    logic             carry_q,     carry_d;
    logic [KW-1:0]    k_q,         k_d;
    logic [WIDTH-1:0] psum_q,      psum_d;
    logic [WIDTH-1:0] sum_q,       sum_d;
    logic             cout_q,      cout_d;
    logic             out_valid_q, out_valid_d;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
    logic             ovf_q,       ovf_d;
`endif

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_res;
    logic             last_chunk;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            k_q         <= '0;
            psum_q      <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            k_q         <= k_d;
            psum_q      <= psum_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    // Next-state and chunk datapath; only a CHUNK-bit ripple sits between registers
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        k_d         = k_q;
        psum_d      = psum_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
        ovf_d       = ovf_q;
`endif
        a_chunk     = a_q[k_q*CHUNK +: CHUNK];
        b_chunk     = b_q[k_q*CHUNK +: CHUNK];
        chunk_res   = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        last_chunk  = (k_q == KW'(N - 1));

        case (state_q)
            IDLE: begin
                if (bus.in_valid && bus.in_ready) begin
                    a_d     = bus.x;
                    b_d     = bus.sub ? ~bus.y : bus.y;
                    carry_d = bus.cin ^ bus.sub;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                psum_d[k_q*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
                carry_d = chunk_res[CHUNK];
                if (last_chunk) begin
                    k_d         = '0;
                    sum_d       = psum_d;
                    cout_d      = chunk_res[CHUNK];
`ifdef CHUNKED_ADDER_OVERFLOW_EN
                    // Carry into the MSB recovered from the MSB sum bit
                    ovf_d       = (a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_res[CHUNK-1])
                                  ^ chunk_res[CHUNK];
`endif
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // Gated by rst so the producer never sees ready while reset is held
    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_chunked_adder.sv
// Scoreboard bench for chunked_adder (WIDTH=32, CHUNK=8): directed vectors, decoupled result monitor.
module tb_chunked_adder;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned CHUNK = 8;
    localparam int TIMEOUT = 20;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    chunked_adder_if #(.WIDTH(WIDTH)) bus ();

    chunked_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endfunction

    // Monitor: compare each completed output handshake against the oldest expectation
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            exp_t e;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=0x%08h required=none", bus.sum);
            end else begin
                e = sb_q.pop_front();
                check("sb_sum", bus.sum, e.sum);
                check("sb_cout", 32'(bus.cout), 32'(e.cout));
`ifdef CHUNKED_ADDER_OVERFLOW_EN
                check("sb_ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands until accepted; returns #1 after the accept edge
    task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s,
                          input bit push, input logic [31:0] es, input logic ec, input logic eo);
        bit   acc;
        exp_t e;
        acc = 1'b0;
        bus.x = a;
        bus.y = b;
        bus.cin = c;
        bus.sub = s;
        bus.in_valid = 1'b1;
        for (int i = 0; i < TIMEOUT && !acc; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) acc = 1'b1;
        end
        if (!acc) begin
            check("accept_timeout", 32'(acc), 32'd1);
        end else begin
            e.sum  = es;
            e.cout = ec;
            e.ovf  = eo;
            if (push) sb_q.push_back(e);
            step();
        end
        bus.in_valid = 1'b0;
        bus.x = $urandom;
        bus.y = $urandom;
        bus.cin = 1'b1;
        bus.sub = 1'b0;
    endtask

    // Count edges from accept until out_valid; in_ready must stay low throughout
    task automatic wait_result(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < TIMEOUT) begin
            check("in_ready_busy", 32'(bus.in_ready), 32'd0);
            step();
            lat++;
        end
        check("in_ready_done", 32'(bus.in_ready), 32'd0);
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.x = '0;
        bus.y = '0;
        bus.cin = 1'b0;
        bus.sub = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) step();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum", bus.sum, 32'h0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        accept(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        wait_result(lat);
        check("latency_full_carry", lat, 32'd4);
        step();

        accept(32'h0000_00D7, 32'h0000_00B5, 1'b1, 1'b0, 1'b1, 32'h0000_018D, 1'b0, 1'b0);
        wait_result(lat);
        check("latency_cin", lat, 32'd4);
        step();

        accept(32'd5, 32'd7, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        wait_result(lat);
        step();

        accept(32'd7, 32'd5, 1'b0, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
        wait_result(lat);
        step();

        // Backpressure: result must hold while the consumer stalls
        bus.out_ready = 1'b0;
        accept(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1, 32'h2345_6789, 1'b0, 1'b0);
        wait_result(lat);
        for (int i = 0; i < 3; i++) begin
            bus.x = ~bus.x;
            bus.y = bus.y + 32'd1;
            bus.in_valid = ~bus.in_valid;
            step();
            check("stall_sum", bus.sum, 32'h2345_6789);
            check("stall_cout", 32'(bus.cout), 32'd0);
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("release_in_ready", 32'(bus.in_ready), 32'd1);
        check("release_out_valid", 32'(bus.out_valid), 32'd0);
        step();
        check("no_spurious_accept", 32'(bus.in_ready), 32'd1);

        // Reset two chunks into an operation
        accept(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b1;
        step();
        check("midrun_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrun_rst_sum", bus.sum, 32'h0);
        check("midrun_rst_cout", 32'(bus.cout), 32'd0);
        check("midrun_rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("midrun_post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        accept(32'd3, 32'd4, 1'b0, 1'b0, 1'b1, 32'd7, 1'b0, 1'b0);
        wait_result(lat);
        check("latency_after_rst", lat, 32'd4);
        step();

`ifdef CHUNKED_ADDER_OVERFLOW_EN
        accept(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
        wait_result(lat);
        step();
        accept(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        wait_result(lat);
        step();
        accept(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 32'h0000_0002, 1'b0, 1'b0);
        wait_result(lat);
        step();
`endif

        repeat (2) step();
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so a stuck handshake still ends the run
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
